spy_delay_scheduler: RTL and testbench
======================================

# spy_delay_scheduler

Measurement controller for the spy delay-path instances. Sequences up to NUM_PATHS paths under test: drives a launch transition into each enabled path, counts clock cycles until the path output changes, compares the count against a golden delay window, and reports per-path result and alarm. Sits between the host/test logic and the path-under-test array; the paths themselves stay purely combinational.

## Interface
- NUM_PATHS, 4: number of paths under test (1..8)
- CNT_W, 8: delay counter width
- SETTLE, 4: idle cycles before each launch (path and synchronizer quiesce)
- TIMEOUT, 200: max count before abort (< 2^CNT_W)
- clk  in  1  single system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  begin a sweep; sampled in IDLE only
- path_mask  in  NUM_PATHS  enable per path; latched at start
- golden  in  CNT_W  expected delay count
- tol  in  CNT_W  allowed deviation; window is golden±tol inclusive
- launch  out  NUM_PATHS  drive to path inputs
- path_out  in  NUM_PATHS  path outputs (asynchronous to clk)
- busy  out  1  sweep in progress
- res_valid  out  1  one-cycle pulse per measured path
- res_path  out  3  index of reported path
- res_count  out  CNT_W  measured count
- res_alarm  out  1  count outside window or timeout
- res_timeout  out  1  path never toggled
- done  out  1  one-cycle pulse at sweep end

## Operation
- Reset: launch=0, busy=0, res_valid=0, res_path=0, res_count=0, res_alarm=0, res_timeout=0, done=0, FSM=IDLE.
- States: IDLE, SELECT, SETTLE, MEASURE, RECORD, FINISH.
- IDLE: start=1 → latch path_mask, golden, tol; idx=0; busy=1; → SELECT. start ignored in other states.
- SELECT: find lowest enabled index ≥ idx; none → FINISH; else → SETTLE with cycle counter cleared.
- SETTLE: hold launch; after SETTLE cycles capture baseline = synced path_out[idx]; → MEASURE, toggling launch[idx] on the transition cycle.
- MEASURE: count increments every cycle starting at 1 on the cycle after the toggle; exit when synced path_out[idx] != baseline → RECORD; count==TIMEOUT → RECORD with timeout set.
- RECORD: res_valid=1 for one cycle; res_count=count (TIMEOUT on timeout); res_alarm = timeout OR |count−golden| > tol, difference computed in CNT_W+1 bits; idx=idx+1; → SELECT.
- FINISH: done=1 one cycle, busy=0, → IDLE.
- launch bits hold their last level between sweeps (alternating polarity is intended); only launch[idx] ever toggles.
- path_mask=0 at start: busy for two cycles, done with no res_valid.
- res_* hold last values until next RECORD.
- Reset mid-sweep: immediate return to reset values; no done pulse.

## Timing
- path_out passes a 2-flop synchronizer; reported count = true delay in cycles + 2 (sync latency), ±1 cycle quantization.
- Per-path latency: 1 (SELECT) + SETTLE + count + 1 (RECORD) cycles.
- done pulses the cycle after the last RECORD + 1 (SELECT finding no path).
- res_valid and done are never high in the same cycle.

## Configuration
- SPY_DELAY_AVG_EN defined: each path launched 4 times (alternating polarity, SETTLE before each); counts summed in CNT_W+2 bits; res_count = sum>>2; any timeout in the 4 → res_timeout=1, res_count=TIMEOUT.
- Undefined: single launch per path as above.

## Structure
- spy_delay_pkg: FSM state enum, default CNT_W/SETTLE/TIMEOUT constants, alarm-window compare function.
- Sub-module spy_sync2ff: 2-flop synchronizer, parameterized width, reset to 0; instanced once for NUM_PATHS bits.

## Test plan
- Path model with 10-cycle delay, mask=4'b0001, golden=12, tol=1 → one res_valid, res_path=0, res_count=12, res_alarm=0, then done.
- Path 2 model 20 cycles, mask=4'b0100, golden=12, tol=2 → res_count=22, res_alarm=1.
- Path 1 stuck output, mask=4'b0010 → res_count=200, res_timeout=1, res_alarm=1 after 1+4+200+1 cycles.
- mask=4'b1011, delays 5/7/–/9 → res_valid sequence res_path 0,1,3 counts 7,9,11; done after last.
- Assert rst_n low during MEASURE of path 1 → all outputs 0 immediately, no done; new start sweeps from path 0.
- SPY_DELAY_AVG_EN with rise delay 8, fall delay 12 → res_count=(10+14+10+14)>>2=12.

Source files
------------

// File: rtl/spy_delay_pkg.sv
// Shared types and constants for the spy delay-path measurement controller.
// The optional averaging mode is selected with the SPY_DELAY_AVG_EN macro.
package spy_delay_pkg;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_SETTLE  = 4;
  localparam int DEF_TIMEOUT = 200;
  // Widest counter the window compare accepts; narrower counts are zero-extended.
  localparam int MAX_CNT_W   = 16;
  // One bit wider than res_path so idx can step past the last path without wrapping.
  localparam int IDX_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_MEASURE,
    ST_RECORD,
    ST_FINISH
  } state_e;

  // True when |count - golden| > tol, using a signed difference one bit wider than the operands.
  function automatic logic out_of_window(input logic [MAX_CNT_W-1:0] count,
                                         input logic [MAX_CNT_W-1:0] golden,
                                         input logic [MAX_CNT_W-1:0] tol);
    logic [MAX_CNT_W:0] diff;
    diff = {1'b0, count} - {1'b0, golden};
    if (diff[MAX_CNT_W]) diff = -diff;
    return diff > {1'b0, tol};
  endfunction

endpackage

// File: rtl/spy_sync2ff.sv
// Two-flop synchronizer for the asynchronous path outputs; resets to 0.
module spy_sync2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments so both stages sample the pre-edge values and form a real two-stage chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spy_delay_scheduler.sv
// Sweeps enabled delay paths: settle, launch a transition, count cycles to the
// synchronized response, and report count/alarm per path. Define SPY_DELAY_AVG_EN for 4-launch averaging.
module spy_delay_scheduler
  import spy_delay_pkg::*;
#(
  parameter int NUM_PATHS = 4,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int SETTLE    = DEF_SETTLE,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_PATHS-1:0] path_mask,
  input  logic [CNT_W-1:0]     golden,
  input  logic [CNT_W-1:0]     tol,
  output logic [NUM_PATHS-1:0] launch,
  input  logic [NUM_PATHS-1:0] path_out,
  output logic                 busy,
  output logic                 res_valid,
  output logic [2:0]           res_path,
  output logic [CNT_W-1:0]     res_count,
  output logic                 res_alarm,
  output logic                 res_timeout,
  output logic                 done
);

  localparam int SET_W = $clog2(SETTLE + 1);
`ifdef SPY_DELAY_AVG_EN
  localparam int SUM_W = CNT_W + 2;
`endif

  state_e               state_q, state_d;
  logic [NUM_PATHS-1:0] mask_q, mask_d;
  logic [NUM_PATHS-1:0] sel_q, sel_d;
  logic [NUM_PATHS-1:0] launch_q, launch_d;
  logic [CNT_W-1:0]     golden_q, golden_d;
  logic [CNT_W-1:0]     tol_q, tol_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic                 base_q, base_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 res_valid_q, res_valid_d;
  logic [2:0]           res_path_q, res_path_d;
  logic [CNT_W-1:0]     res_count_q, res_count_d;
  logic                 res_alarm_q, res_alarm_d;
  logic                 res_timeout_q, res_timeout_d;
`ifdef SPY_DELAY_AVG_EN
  logic [1:0]           rep_q, rep_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [SUM_W-1:0]     avg_sum;
`endif

  logic [NUM_PATHS-1:0] sync_q;
  logic                 path_bit;
  logic                 found;
  logic [IDX_W-1:0]     found_idx;
  logic [NUM_PATHS-1:0] found_oh;
  logic                 meas_done;
  logic                 rec_en;
  logic                 rec_to;
  logic [CNT_W-1:0]     rec_cnt;

  spy_sync2ff #(.WIDTH(NUM_PATHS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (path_out),
    .q     (sync_q)
  );

  assign path_bit = |(sync_q & sel_q);

  // Lowest enabled path at or above idx; the downward loop leaves the lowest hit last.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    found_oh  = '0;
    for (int i = NUM_PATHS - 1; i >= 0; i--) begin
      if (mask_q[i] && (i >= int'(idx_q))) begin
        found       = 1'b1;
        found_idx   = IDX_W'(i);
        found_oh    = '0;
        found_oh[i] = 1'b1;
      end
    end
  end

  // NOTE: every variable gets its default before the case so no path through the block leaves one unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    sel_d         = sel_q;
    launch_d      = launch_q;
    golden_d      = golden_q;
    tol_d         = tol_q;
    count_d       = count_q;
    idx_d         = idx_q;
    settle_d      = settle_q;
    base_d        = base_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    res_valid_d   = 1'b0;
    res_path_d    = res_path_q;
    res_count_d   = res_count_q;
    res_alarm_d   = res_alarm_q;
    res_timeout_d = res_timeout_q;
    meas_done     = 1'b0;
    rec_en        = 1'b0;
    rec_to        = 1'b0;
    rec_cnt       = count_q;
`ifdef SPY_DELAY_AVG_EN
    rep_d         = rep_q;
    sum_d         = sum_q;
    avg_sum       = sum_q + SUM_W'(count_q);
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d   = path_mask;
          golden_d = golden;
          tol_d    = tol;
          idx_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (found) begin
          idx_d    = found_idx;
          sel_d    = found_oh;
          settle_d = '0;
`ifdef SPY_DELAY_AVG_EN
          rep_d    = '0;
          sum_d    = '0;
`endif
          state_d  = ST_SETTLE;
        end else begin
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end
      end

      ST_SETTLE: begin
        if (settle_q == SET_W'(SETTLE - 1)) begin
          base_d   = path_bit;
          launch_d = launch_q ^ sel_q;
          count_d  = '0;
          state_d  = ST_MEASURE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      ST_MEASURE: begin
        if (path_bit != base_q) begin
          meas_done = 1'b1;
        end else if (count_q == CNT_W'(TIMEOUT - 1)) begin
          meas_done = 1'b1;
          rec_to    = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end

        if (meas_done) begin
`ifdef SPY_DELAY_AVG_EN
          if (!rec_to && (rep_q != 2'd3)) begin
            sum_d    = avg_sum;
            rep_d    = rep_q + 1'b1;
            settle_d = '0;
            state_d  = ST_SETTLE;
          end else begin
            rec_cnt = avg_sum[SUM_W-1:2];
            rec_en  = 1'b1;
          end
`else
          rec_en = 1'b1;
`endif
        end
      end

      ST_RECORD: begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_SELECT;
      end

      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Result registers load on entry to RECORD so res_valid is high during that state.
    if (rec_en) begin
      res_valid_d   = 1'b1;
      res_path_d    = idx_q[2:0];
      res_timeout_d = rec_to;
      res_count_d   = rec_to ? CNT_W'(TIMEOUT) : rec_cnt;
      res_alarm_d   = rec_to | out_of_window(MAX_CNT_W'(rec_cnt), MAX_CNT_W'(golden_q),
                                             MAX_CNT_W'(tol_q));
      state_d       = ST_RECORD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      sel_q         <= '0;
      launch_q      <= '0;
      golden_q      <= '0;
      tol_q         <= '0;
      count_q       <= '0;
      idx_q         <= '0;
      settle_q      <= '0;
      base_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_path_q    <= '0;
      res_count_q   <= '0;
      res_alarm_q   <= 1'b0;
      res_timeout_q <= 1'b0;
`ifdef SPY_DELAY_AVG_EN
      rep_q         <= '0;
      sum_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      sel_q         <= sel_d;
      launch_q      <= launch_d;
      golden_q      <= golden_d;
      tol_q         <= tol_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      settle_q      <= settle_d;
      base_q        <= base_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      res_valid_q   <= res_valid_d;
      res_path_q    <= res_path_d;
      res_count_q   <= res_count_d;
      res_alarm_q   <= res_alarm_d;
      res_timeout_q <= res_timeout_d;
`ifdef SPY_DELAY_AVG_EN
      rep_q         <= rep_d;
      sum_q         <= sum_d;
`endif
    end
  end

  assign launch      = launch_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign res_valid   = res_valid_q;
  assign res_path    = res_path_q;
  assign res_count   = res_count_q;
  assign res_alarm   = res_alarm_q;
  assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_spy_delay_scheduler.sv
// Scoreboard bench for spy_delay_scheduler: a clocked path model responds to launch
// after a per-path rise/fall delay; a monitor checks every res_valid/done against queued expectations.
module tb_spy_delay_scheduler;

  localparam int NP = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NP-1:0] path_mask;
  logic [CW-1:0] golden;
  logic [CW-1:0] tol;
  logic [NP-1:0] launch;
  logic [NP-1:0] path_out = '0;
  logic          busy;
  logic          res_valid;
  logic [2:0]    res_path;
  logic [CW-1:0] res_count;
  logic          res_alarm;
  logic          res_timeout;
  logic          done;

  always #5 clk = ~clk;

  spy_delay_scheduler #(
    .NUM_PATHS (NP),
    .CNT_W     (CW),
    .SETTLE    (4),
    .TIMEOUT   (200)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .path_mask   (path_mask),
    .golden      (golden),
    .tol         (tol),
    .launch      (launch),
    .path_out    (path_out),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_path    (res_path),
    .res_count   (res_count),
    .res_alarm   (res_alarm),
    .res_timeout (res_timeout),
    .done        (done)
  );

  typedef struct packed {
    logic [2:0]    path;
    logic [CW-1:0] count;
    logic          alarm;
    logic          timeout;
  } res_t;

  res_t exp_q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  // Path model: output follows launch after rise_d/fall_d clock cycles; stuck paths never move.
  int          rise_d[NP];
  int          fall_d[NP];
  logic [NP-1:0] stuck = '0;
  logic [63:0] hist[NP] = '{default: '0};
  logic [63:0] h_tmp;

  always @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      h_tmp = {hist[i][62:0], launch[i]};
      hist[i] <= h_tmp;
      if (!stuck[i])
        path_out[i] <= path_out[i] ? h_tmp[fall_d[i]-1] : h_tmp[rise_d[i]-1];
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t mk(input int p, input int c, input int a, input int t);
    res_t r;
    r.path    = 3'(p);
    r.count   = CW'(c);
    r.alarm   = a[0];
    r.timeout = t[0];
    return r;
  endfunction

  // Monitor: pops one expectation per res_valid, checks ordering on done.
  always @(negedge clk) begin
    res_t e;
    if (rst_n && (res_valid || done))
      check("valid_done_exclusive", int'(res_valid && done), 0);
    if (rst_n && res_valid) begin
      check("result_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("res_path", int'(res_path), int'(e.path));
        check("res_count", int'(res_count), int'(e.count));
        check("res_alarm", int'(res_alarm), int'(e.alarm));
        check("res_timeout", int'(res_timeout), int'(e.timeout));
      end
    end
    if (rst_n && done) begin
      done_cnt++;
      check("done_after_all_results", exp_q.size(), 0);
    end
  end

  task automatic set_delay(input int p, input int r, input int f);
    rise_d[p] = r;
    fall_d[p] = f;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_launch"}, int'(launch), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_res_valid"}, int'(res_valid), 0);
    check({tag, "_res_path"}, int'(res_path), 0);
    check({tag, "_res_count"}, int'(res_count), 0);
    check({tag, "_res_alarm"}, int'(res_alarm), 0);
    check({tag, "_res_timeout"}, int'(res_timeout), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  // Quiesce paths, then pulse start for one cycle; returns on the negedge after the sampling edge.
  task automatic run_sweep(input logic [NP-1:0] mask, input int golden_v, input int tol_v);
    repeat (40) @(negedge clk);
    path_mask = mask;
    golden    = CW'(golden_v);
    tol       = CW'(tol_v);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c;
    int d0;
    c  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    check({name, "_done_seen"}, done_cnt - d0, 1);
    @(negedge clk);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    int bc;
    int d0;

    for (int i = 0; i < NP; i++) set_delay(i, 3, 3);
    rst_n     = 1'b0;
    start     = 1'b0;
    path_mask = '0;
    golden    = '0;
    tol       = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 10-cycle path: count = delay + 2 sync cycles
    set_delay(0, 10, 10);
    exp_q.push_back(mk(0, 12, 0, 0));
    run_sweep(4'b0001, 12, 1);
    wait_done("single_ok", 2000);

    // Window edges with golden above the count: diff 2 within tol, diff 3 outside
    exp_q.push_back(mk(0, 12, 0, 0));
    run_sweep(4'b0001, 14, 2);
    wait_done("window_edge_in", 2000);
    exp_q.push_back(mk(0, 12, 1, 0));
    run_sweep(4'b0001, 15, 2);
    wait_done("window_edge_out", 2000);

    // Slow path 2 -> alarm
    set_delay(2, 20, 20);
    exp_q.push_back(mk(2, 22, 1, 0));
    run_sweep(4'b0100, 12, 2);
    wait_done("slow_path", 2000);

    // Stuck path 1 -> timeout after SELECT + SETTLE + TIMEOUT + RECORD cycles
    stuck[1] = 1'b1;
    exp_q.push_back(mk(1, 200, 1, 1));
    run_sweep(4'b0010, 12, 2);
    cyc = 1;
    while (!res_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout_latency", cyc, 206);
    wait_done("timeout", 2000);
    stuck[1] = 1'b0;

    // Multi-path sweep skipping path 2
    set_delay(0, 5, 5);
    set_delay(1, 7, 7);
    set_delay(2, 3, 3);
    set_delay(3, 9, 9);
    exp_q.push_back(mk(0, 7, 0, 0));
    exp_q.push_back(mk(1, 9, 0, 0));
    exp_q.push_back(mk(3, 11, 1, 0));
    run_sweep(4'b1011, 8, 2);
    wait_done("multi", 3000);

    // Empty mask: busy for SELECT and FINISH, done with no result
    d0 = done_cnt;
    bc = 0;
    run_sweep(4'b0000, 8, 2);
    for (int k = 0; k < 6; k++) begin
      if (busy) bc++;
      @(negedge clk);
    end
    check("empty_mask_busy_cycles", bc, 2);
    check("empty_mask_done", done_cnt - d0, 1);

    // Reset during MEASURE of path 1, then a fresh sweep starts from path 0
    d0 = done_cnt;
    exp_q.push_back(mk(0, 7, 0, 0));
    run_sweep(4'b0011, 8, 2);
    cyc = 0;
    while (!(res_valid && res_path == 3'd0) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("pre_reset_path0_seen", int'(res_valid), 1);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("mid_reset_no_done", done_cnt - d0, 0);
    check("mid_reset_queue_empty", exp_q.size(), 0);
    exp_q.push_back(mk(0, 7, 0, 0));
    exp_q.push_back(mk(1, 9, 0, 0));
    run_sweep(4'b0011, 8, 2);
    wait_done("after_reset", 3000);

`ifdef SPY_DELAY_AVG_EN
    // Asymmetric path: counts 10/14/10/14 average to 12
    set_delay(0, 8, 12);
    exp_q.push_back(mk(0, 12, 0, 0));
    run_sweep(4'b0001, 12, 0);
    wait_done("avg", 3000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
